sda_mmio_ctrl: RTL and testbench
================================

Name: sda_mmio_ctrl

Overview:
- Memory-mapped I/O front end that sits directly upstream of the seven-segment display adapter (SDA) in the LC-3 datapath.
- Decodes LC-3 MIO accesses to the three SDA device registers.
- On writes, issues exactly one single-cycle load strobe plus registered data to the SDA, then waits for the SDA's WR acknowledge.
- On reads, returns the register contents, and in both cases produces the LC-3 memory-ready pulse R.

Parameters:
- SDAER_ADDR, 16'hFE20, address of the SDA enable register
- SDADR_ADDR, 16'hFE22, address of the SDA digit register
- SDASR_ADDR, 16'hFE24, address of the SDA segment-select register
- ACK_TIMEOUT, 4, cycles to wait in WAIT_ACK for WR before aborting with ERR (legal range 1..15)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- MIO_EN  input  1  LC-3 memory/IO request valid
- R_W  input  1  1 = write, 0 = read
- MAR  input  16  access address
- MDR  input  16  write data from the LC-3
- WR  input  1  SDA write acknowledge, high for one cycle after a load
- SDAER  input  16  current SDA enable register
- SDADR  input  16  current SDA digit register
- SDASR  input  16  current SDA segment-select register
- HIT  output  1  combinational: MIO_EN high and MAR equals one of the three addresses
- LD_SDAER  output  1  registered load strobe to the SDA
- LD_SDADR  output  1  registered load strobe to the SDA
- LD_SDASR  output  1  registered load strobe to the SDA
- MDR_OUT  output  16  registered write data to the SDA MDR input
- RD_DATA  output  16  registered read data
- R  output  1  registered memory-ready, one-cycle pulse
- ERR  output  1  registered; set when a write times out

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE; LD_* = 0; MDR_OUT = 0; RD_DATA = 0; R = 0; ERR = 0; timeout counter = 0.
- Reset asserted mid-operation aborts the access immediately. LD_* and R drop asynchronously, and no R is ever issued for the aborted access.

State machine:
- IDLE: on HIT, capture the address select (one-hot) and MDR.
  - Write (R_W = 1) -> WRITE.
  - Read (R_W = 0) -> READ.
  - Non-hitting requests are ignored: no strobe, no R, stay in IDLE.
- WRITE (exactly 1 cycle):
  - Drive the selected LD_* high and MDR_OUT = captured MDR.
  - Clear ERR, clear the counter, -> WAIT_ACK.
- WAIT_ACK:
  - All LD_* are low.
  - WR = 1 -> DONE.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, set ERR = 1 and -> DONE.
  - WR arriving in the same cycle the timeout is reached: WR wins, ERR stays 0.
- READ (1 cycle):
  - RD_DATA = the selected register, masked to its implemented bits: {15'b0, SDAER[0]}, {15'b0, SDADR[0]}, {13'b0, SDASR[2:0]}.
  - Clear ERR, -> DONE.
- DONE: R = 1 for this one cycle, -> RELEASE.
- RELEASE: wait for MIO_EN = 0, then -> IDLE. A request still held high is never re-executed; back-to-back accesses require MIO_EN low for at least 1 cycle.

Hold and timing rules:
- RD_DATA and ERR hold their values until the next accepted access.
- MDR_OUT holds its value until the next write.
- At most one LD_* is ever high, and only in the WRITE state.
- WR seen in any state other than WAIT_ACK is ignored.
- MAR, MDR and R_W changing after acceptance have no effect.
- Write latency: accept at edge 0, LD high in cycle 1, WR in cycle 2, R high in cycle 3.
- Read latency: accept at edge 0, R high in cycle 2 with RD_DATA valid.

Test Plan:
- Reset, then write MAR = FE22, MDR = 0001, with a model SDA returning WR one cycle after the load -> LD_SDADR high exactly 1 cycle with MDR_OUT = 0001; R pulses 1 cycle, 3 cycles after accept; ERR = 0; other LD_* stay 0.
- Write FE24 with MDR = FFFD, then read FE24 -> RD_DATA = 0005; R pulses 2 cycles after the read accept.
- Write FE20 with WR tied low, ACK_TIMEOUT = 4 -> R pulses after 4 WAIT_ACK cycles with ERR = 1; a following successful write clears ERR to 0.
- MIO_EN high with MAR = FE26, and separately MAR = 3000 -> HIT = 0; no LD_*, no R; state stays IDLE.
- MIO_EN held high for 10 cycles on a write to FE22 -> only one LD_SDADR pulse and one R; the next access is accepted only after MIO_EN drops for 1 cycle.
- rst_n pulled low during WAIT_ACK, then released -> LD_*, R and ERR are 0 immediately; no R follows; a subsequent read of FE20 completes normally.

Source files
------------

// File: rtl/sda_mmio_ctrl.sv
// LC-3 MIO front end for the seven-segment display adapter: decodes the three
// SDA registers, issues one load strobe per write and returns the R pulse.
module sda_mmio_ctrl #(
  parameter logic [15:0] SDAER_ADDR  = 16'hFE20,
  parameter logic [15:0] SDADR_ADDR  = 16'hFE22,
  parameter logic [15:0] SDASR_ADDR  = 16'hFE24,
  parameter int          ACK_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        WR,
  input  logic [15:0] SDAER,
  input  logic [15:0] SDADR,
  input  logic [15:0] SDASR,
  output logic        HIT,
  output logic        LD_SDAER,
  output logic        LD_SDADR,
  output logic        LD_SDASR,
  output logic [15:0] MDR_OUT,
  output logic [15:0] RD_DATA,
  output logic        R,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_ACK, S_READ, S_DONE, S_RELEASE
  } state_t;

  state_t      r_state, w_next;
  logic [2:0]  w_sel, r_sel, r_ld;
  logic [15:0] r_mdr_out, r_rd_data, w_rd;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic        r_r, r_err, w_timeout;
  logic        w_unused;

  // Only the low bits of each SDA register are implemented.
  assign w_unused  = ^{SDAER[15:1], SDADR[15:1], SDASR[15:3]};

  assign w_sel     = {MAR == SDASR_ADDR, MAR == SDADR_ADDR, MAR == SDAER_ADDR};
  assign HIT       = MIO_EN & (|w_sel);
  assign w_cnt_nx  = r_cnt + 4'd1;
  assign w_timeout = (w_cnt_nx == 4'(ACK_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (HIT) w_next = R_W ? S_WRITE : S_READ;
      S_WRITE:    w_next = S_WAIT_ACK;
      S_WAIT_ACK: if (WR || w_timeout) w_next = S_DONE;
      S_READ:     w_next = S_DONE;
      S_DONE:     w_next = S_RELEASE;
      S_RELEASE:  if (!MIO_EN) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd = '0;
    if (r_sel[0])      w_rd = {15'b0, SDAER[0]};
    else if (r_sel[1]) w_rd = {15'b0, SDADR[0]};
    else if (r_sel[2]) w_rd = {13'b0, SDASR[2:0]};
  end

  // Strobe is registered on the accept edge so it is high for exactly the WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_ld      <= '0;
      r_mdr_out <= '0;
      r_rd_data <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_r       <= 1'b0;
    end else begin
      r_ld <= '0;
      r_r  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: if (HIT) begin
          r_sel <= w_sel;
          if (R_W) begin
            r_ld      <= w_sel;
            r_mdr_out <= MDR;
          end
        end
        S_WRITE: begin
          r_err <= 1'b0;
          r_cnt <= '0;
        end
        S_WAIT_ACK: if (!WR) begin
          r_cnt <= w_cnt_nx;
          if (w_timeout) r_err <= 1'b1;
        end
        S_READ: begin
          r_rd_data <= w_rd;
          r_err     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign LD_SDAER = r_ld[0];
  assign LD_SDADR = r_ld[1];
  assign LD_SDASR = r_ld[2];
  assign MDR_OUT  = r_mdr_out;
  assign RD_DATA  = r_rd_data;
  assign R        = r_r;
  assign ERR      = r_err;

endmodule

// File: tb/tb_sda_mmio_ctrl.sv
// Bench for sda_mmio_ctrl: vector table plus hand sequences, with a model SDA
// and a queue of expected completions checked whenever R pulses.
module tb_sda_mmio_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        MIO_EN = 1'b0, R_W = 1'b0, WR;
  logic [15:0] MAR = '0, MDR = '0;
  logic [15:0] SDAER = '0, SDADR = '0, SDASR = '0;
  logic        HIT, LD_SDAER, LD_SDADR, LD_SDASR, R, ERR;
  logic [15:0] MDR_OUT, RD_DATA;

  sda_mmio_ctrl dut (
    .clk(clk), .rst_n(rst_n), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR), .MDR(MDR),
    .WR(WR), .SDAER(SDAER), .SDADR(SDADR), .SDASR(SDASR), .HIT(HIT),
    .LD_SDAER(LD_SDAER), .LD_SDADR(LD_SDADR), .LD_SDASR(LD_SDASR),
    .MDR_OUT(MDR_OUT), .RD_DATA(RD_DATA), .R(R), .ERR(ERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model SDA: loads on strobe, acknowledges one cycle later unless disabled.
  logic wr_en = 1'b1, wr_q = 1'b0;
  assign WR = wr_q;
  always @(posedge clk) begin
    wr_q <= (LD_SDAER | LD_SDADR | LD_SDASR) & wr_en;
    if (LD_SDAER) SDAER <= MDR_OUT;
    if (LD_SDADR) SDADR <= MDR_OUT;
    if (LD_SDASR) SDASR <= MDR_OUT;
  end

  typedef struct {
    logic rw; logic [15:0] addr; logic [15:0] mdr; logic wr_en;
    logic [15:0] exp_rd; logic exp_err; int lat;
  } vec_t;
  typedef struct {
    logic rw; logic [2:0] sel; logic [15:0] mdr; logic [15:0] exp_rd;
    logic exp_err; int exp_cyc;
  } exp_t;

  exp_t        q[$];
  vec_t        tbl[13];
  int          n_chk = 0, n_fail = 0, ld_cnt = 0, ld_total = 0, r_total = 0;
  logic [15:0] last_rd = '0;
  logic        r_prev = 1'b0;
  logic [2:0]  mon_ld;
  exp_t        mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] sel_of(input logic [15:0] a);
    return {a == 16'hFE24, a == 16'hFE22, a == 16'hFE20};
  endfunction

  // Accept edge is the posedge after this call; cycle k after it samples cyc+k.
  task automatic push(input vec_t v);
    exp_t e;
    e.rw = v.rw; e.sel = sel_of(v.addr); e.mdr = v.mdr;
    e.exp_rd = v.exp_rd; e.exp_err = v.exp_err; e.exp_cyc = cyc + 1 + v.lat;
    q.push_back(e);
  endtask

  task automatic do_acc(input vec_t v, input int hold);
    int n;
    MIO_EN = 1'b1; MAR = v.addr; MDR = v.mdr; R_W = v.rw; wr_en = v.wr_en;
    push(v);
    #1 chk("hit", HIT, 1);
    @(posedge clk); @(negedge clk);
    // Retarget to another valid address while held: must not be re-executed.
    MAR = (v.addr == 16'hFE24) ? 16'hFE20 : 16'hFE24;
    MDR = ~v.mdr; R_W = ~v.rw;
    n = 0;
    while (!R && n < 20) begin @(negedge clk); n++; end
    chk("r_seen", R, 1);
    repeat (hold) @(negedge clk);
    MIO_EN = 1'b0;
    @(negedge clk);
  endtask

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete(); ld_cnt = 0; last_rd = '0; r_prev = 1'b0;
    end else begin
      mon_ld = {LD_SDASR, LD_SDADR, LD_SDAER};
      if (mon_ld != 3'b000) begin
        ld_cnt++; ld_total++;
        chk("ld_onehot", $countones(mon_ld), 1);
        if (q.size() > 0) begin
          chk("ld_sel", mon_ld, q[0].sel);
          chk("mdr_out", MDR_OUT, q[0].mdr);
        end
      end
      if (R) begin
        r_total++;
        chk("r_one_cycle", r_prev, 0);
        if (q.size() == 0) chk("r_expected", q.size(), 1);
        else begin
          mon_e = q.pop_front();
          chk("r_cycle", cyc, mon_e.exp_cyc);
          chk("err", ERR, mon_e.exp_err);
          if (!mon_e.rw) begin
            chk("rd_data", RD_DATA, mon_e.exp_rd);
            last_rd = mon_e.exp_rd;
          end else chk("rd_hold", RD_DATA, last_rd);
          chk("ld_count", ld_cnt, mon_e.rw ? 1 : 0);
          ld_cnt = 0;
        end
      end
      r_prev = R;
    end
  end

  int ld0, r0;
  vec_t v;

  initial begin
    //             rw   addr      mdr      wr  exp_rd   err lat
    tbl[0]  = '{1'b1, 16'hFE22, 16'h0001, 1'b1, 16'h0000, 1'b0, 2};
    tbl[1]  = '{1'b1, 16'hFE24, 16'hFFFD, 1'b1, 16'h0000, 1'b0, 2};
    tbl[2]  = '{1'b0, 16'hFE24, 16'h1234, 1'b1, 16'h0005, 1'b0, 1};
    tbl[3]  = '{1'b1, 16'hFE20, 16'h0003, 1'b0, 16'h0000, 1'b1, 5};
    tbl[4]  = '{1'b1, 16'hFE20, 16'h0001, 1'b1, 16'h0000, 1'b0, 2};
    tbl[5]  = '{1'b0, 16'hFE20, 16'h0000, 1'b1, 16'h0001, 1'b0, 1};
    tbl[6]  = '{1'b0, 16'hFE22, 16'hFFFF, 1'b1, 16'h0001, 1'b0, 1};
    tbl[7]  = '{1'b1, 16'hFE22, 16'hFFFE, 1'b1, 16'h0000, 1'b0, 2};
    tbl[8]  = '{1'b0, 16'hFE22, 16'h0000, 1'b1, 16'h0000, 1'b0, 1};
    tbl[9]  = '{1'b1, 16'hFE24, 16'h0002, 1'b1, 16'h0000, 1'b0, 2};
    tbl[10] = '{1'b0, 16'hFE24, 16'h0000, 1'b1, 16'h0002, 1'b0, 1};
    tbl[11] = '{1'b1, 16'hFE20, 16'h0000, 1'b0, 16'h0000, 1'b1, 5};
    tbl[12] = '{1'b0, 16'hFE20, 16'h0000, 1'b1, 16'h0000, 1'b0, 1};

    repeat (3) @(negedge clk);
    chk("rst_ld", {LD_SDASR, LD_SDADR, LD_SDAER}, 0);
    chk("rst_r", R, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_mdr_out", MDR_OUT, 0);
    rst_n = 1'b1;
    @(negedge clk);
    MAR = 16'hFE22;
    #1 chk("hit_no_en", HIT, 0);
    @(negedge clk);

    for (int i = 0; i < 13; i++) do_acc(tbl[i], 1);

    // Non-hitting requests.
    ld0 = ld_total; r0 = r_total;
    MIO_EN = 1'b1; R_W = 1'b1; MAR = 16'hFE26;
    #1 chk("hit_fe26", HIT, 0);
    repeat (5) @(negedge clk);
    MAR = 16'h3000;
    #1 chk("hit_3000", HIT, 0);
    repeat (5) @(negedge clk);
    MIO_EN = 1'b0;
    chk("miss_no_ld", ld_total - ld0, 0);
    chk("miss_no_r", r_total - r0, 0);
    @(negedge clk);

    // Request held high for ~10 cycles: one strobe, one R.
    ld0 = ld_total; r0 = r_total;
    v = '{1'b1, 16'hFE22, 16'h0001, 1'b1, 16'h0000, 1'b0, 2};
    do_acc(v, 7);
    chk("hold_ld_once", ld_total - ld0, 1);
    chk("hold_r_once", r_total - r0, 1);
    v = '{1'b0, 16'hFE22, 16'h0000, 1'b1, 16'h0001, 1'b0, 1};
    do_acc(v, 1);

    // Reset during WAIT_ACK aborts the write with no R.
    v = '{1'b1, 16'hFE20, 16'h0000, 1'b0, 16'h0000, 1'b0, 5};
    MIO_EN = 1'b1; MAR = v.addr; MDR = v.mdr; R_W = 1'b1; wr_en = 1'b0;
    push(v);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0; MIO_EN = 1'b0;
    #1;
    chk("abort_ld", {LD_SDASR, LD_SDADR, LD_SDAER}, 0);
    chk("abort_r", R, 0);
    chk("abort_err", ERR, 0);
    r0 = r_total;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_r", r_total - r0, 0);
    v = '{1'b0, 16'hFE20, 16'h0000, 1'b1, 16'h0000, 1'b0, 1};
    do_acc(v, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
